// File: rtl/alu_arbiter_if.sv
// Handshake and ALU-side signal bundle for alu_arbiter.
// The arbiter uses the slave modport; requesters, consumer and ALU use master.
interface alu_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic [3:0]            req0_op;
  logic [DATA_WIDTH-1:0] req0_a;
  logic [DATA_WIDTH-1:0] req0_b;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [3:0]            req1_op;
  logic [DATA_WIDTH-1:0] req1_a;
  logic [DATA_WIDTH-1:0] req1_b;

  logic [3:0]            alu_op;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_branch;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_branch;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_result, alu_branch, rsp_ready,
    output req0_ready, req1_ready,
    output alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_data, rsp_branch
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_result, alu_branch, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_data, rsp_branch
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// holding ALU inputs for one cycle (or MULDIV_CYCLES for mul/div) per op.
module alu_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  alu_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] CNT_MD = 4'(MULDIV_CYCLES - 1);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_last_grant;
  logic [3:0]            r_cnt;
  logic [3:0]            r_alu_op;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic                  r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_branch;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_accept;
  logic [3:0]            w_op;
  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic                  w_is_muldiv;
  logic                  w_div_zero;

  // Requester 1 wins when alone, or on a tie when requester 0 went last.
  assign w_grant1    = bus.req1_valid && (!bus.req0_valid || !r_last_grant);
  assign w_grant0    = bus.req0_valid && !w_grant1;
  assign w_accept    = (r_state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign w_op        = w_grant1 ? bus.req1_op : bus.req0_op;
  assign w_a         = w_grant1 ? bus.req1_a  : bus.req0_a;
  assign w_b         = w_grant1 ? bus.req1_b  : bus.req0_b;
  assign w_is_muldiv = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_div_zero  = (r_alu_op == OP_DIV) && (r_alu_b == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req0_ready = w_grant0;
        bus.req1_ready = w_grant1;
        if (w_accept) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        if (r_cnt == '0) w_next_state = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_alu_op     <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_id     <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_branch <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_op     <= w_op;
            r_alu_a      <= w_a;
            r_alu_b      <= w_b;
            r_rsp_id     <= w_grant1;
            r_last_grant <= w_grant1;
            r_cnt        <= w_is_muldiv ? CNT_MD : 4'd0;
          end
        end
        S_EXEC: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else if (w_div_zero) begin
            r_rsp_data   <= '1;
            r_rsp_branch <= 1'b0;
          end else begin
            r_rsp_data   <= bus.alu_result;
            r_rsp_branch <= bus.alu_branch;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.alu_op     = r_alu_op;
  assign bus.alu_a      = r_alu_a;
  assign bus.alu_b      = r_alu_b;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_data   = r_rsp_data;
  assign bus.rsp_branch = r_rsp_branch;

endmodule
